// File: rtl/edge_detection_pkg.sv
// Shared types and defaults for the edge-detection pipeline.
package edge_detection_pkg;

  localparam int unsigned H_PIXELS_DEF = 640;
  localparam int unsigned V_LINES_DEF  = 480;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD0,
    RD1,
    CAP,
    OUT
  } lbs_state_t;

  typedef logic [1:0] line_idx_t;
  typedef logic [7:0] pix_t;

  // Modulo-3 increment of a line-buffer slot index.
  function automatic line_idx_t line_inc(input line_idx_t l);
    return (l == 2'd2) ? 2'd0 : l + 2'd1;
  endfunction

endpackage

// File: rtl/lb_addr_gen.sv
// Line-buffer SRAM address: constant per-line base selected by line index, plus column.
module lb_addr_gen
  import edge_detection_pkg::*;
#(
  parameter int unsigned H_PIXELS = H_PIXELS_DEF,
  parameter int unsigned ADDR_W   = 11
) (
  input  line_idx_t         line_idx,
  input  logic [9:0]        x,
  output logic [ADDR_W-1:0] addr
);

  localparam logic [ADDR_W-1:0] BASE1 = ADDR_W'(H_PIXELS);
  localparam logic [ADDR_W-1:0] BASE2 = ADDR_W'(2 * H_PIXELS);

  logic [ADDR_W-1:0] base;

  always_comb begin
    base = '0;
    case (line_idx)
      2'd1:    base = BASE1;
      2'd2:    base = BASE2;
      default: base = '0;
    endcase
  end

  assign addr = base + ADDR_W'(x);

endmodule

// File: rtl/line_buffer_scheduler.sv
// Time-shares a single-port 3-line SRAM between pixel writes and column reads,
// emitting one vertical 3-pixel column per accepted greyscale pixel.
module line_buffer_scheduler
  import edge_detection_pkg::*;
#(
  parameter int unsigned H_PIXELS = H_PIXELS_DEF,
  parameter int unsigned V_LINES  = V_LINES_DEF,
  parameter int unsigned ADDR_W   = 11
) (
  input  logic              I_CORE_CLK,
  input  logic              I_RST,
  input  logic              I_PIX_VALID,
  input  logic [7:0]        I_PIX_DATA,
  input  logic              I_SOF,
  input  logic              I_SOL,
  output logic              O_PIX_READY,
  output logic              O_RAM_EN,
  output logic              O_RAM_WE,
  output logic [ADDR_W-1:0] O_RAM_ADDR,
  output logic [7:0]        O_RAM_WDATA,
  input  logic [7:0]        I_RAM_RDATA,
  output logic              O_COL_VALID,
  output logic [23:0]       O_COL_DATA,
  output logic [9:0]        O_COL_X,
  output logic [8:0]        O_COL_Y,
  input  logic              I_COL_READY,
  output logic              O_ERR_SYNC
);

  localparam logic [9:0] X_LAST = 10'(H_PIXELS - 1);
  localparam logic [8:0] Y_LAST = 9'(V_LINES - 1);

  lbs_state_t state, state_d;

  // Position of the next expected pixel
  logic [9:0] x_q;
  logic [8:0] y_q;
  line_idx_t  line_q;
  logic [1:0] rows_q;
  logic       done_q;
  logic       err_q;
  logic       ready_q;

  // Latched pixel and its resolved position
  pix_t       pix_q;
  logic [9:0] pix_x;
  logic [8:0] pix_y;
  line_idx_t  pix_line;
  logic [1:0] pix_rows;
  pix_t       oldest_q;
  pix_t       middle_q;

  logic       accept;
  logic [9:0] pos_x, nxt_x;
  logic [8:0] pos_y, nxt_y;
  line_idx_t  pos_line, nxt_line;
  logic [1:0] pos_rows, nxt_rows;
  logic       pos_done, nxt_done;
  logic       err_set;

  logic              ram_en, ram_we;
  line_idx_t         rd_line;
  logic [ADDR_W-1:0] gen_addr;

  // Ready is registered so it is low while reset is asserted.
  assign accept = I_PIX_VALID & ready_q;

  // Resolve where the incoming pixel lands (SOF, then SOL realign), then advance.
  always_comb begin
    pos_x    = x_q;
    pos_y    = y_q;
    pos_line = line_q;
    pos_rows = rows_q;
    pos_done = done_q;
    err_set  = 1'b0;
    if (I_SOF) begin
      pos_x    = '0;
      pos_y    = '0;
      pos_line = '0;
      pos_rows = '0;
      pos_done = 1'b0;
    end else begin
      if (I_SOL && (x_q != '0)) begin
        err_set  = 1'b1;
        pos_x    = '0;
        pos_line = line_inc(line_q);
        if (rows_q != 2'd2) pos_rows = rows_q + 2'd1;
        if (y_q == Y_LAST) pos_done = 1'b1;
        else               pos_y    = y_q + 9'd1;
      end
      if (pos_done) err_set = 1'b1;
    end

    nxt_x    = pos_x + 10'd1;
    nxt_y    = pos_y;
    nxt_line = pos_line;
    nxt_rows = pos_rows;
    nxt_done = pos_done;
    if (pos_x == X_LAST) begin
      nxt_x    = '0;
      nxt_line = line_inc(pos_line);
      if (pos_rows != 2'd2) nxt_rows = pos_rows + 2'd1;
      if (pos_y == Y_LAST) nxt_done = 1'b1;
      else                 nxt_y    = pos_y + 9'd1;
    end
  end

  always_comb begin
    state_d = state;
    ram_en  = 1'b0;
    ram_we  = 1'b0;
    rd_line = pix_line;
    case (state)
      IDLE: if (accept) state_d = WR;
      WR: begin
        ram_en  = 1'b1;
        ram_we  = 1'b1;
        state_d = RD0;
      end
      RD0: begin
        ram_en  = 1'b1;
        rd_line = line_inc(pix_line);
        state_d = RD1;
      end
      RD1: begin
        ram_en  = 1'b1;
        rd_line = line_inc(line_inc(pix_line));
        state_d = CAP;
      end
      CAP:     state_d = OUT;
      OUT:     if (I_COL_READY) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge I_CORE_CLK or posedge I_RST) begin
    if (I_RST) begin
      state    <= IDLE;
      ready_q  <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      line_q   <= '0;
      rows_q   <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      pix_q    <= '0;
      pix_x    <= '0;
      pix_y    <= '0;
      pix_line <= '0;
      pix_rows <= '0;
      oldest_q <= '0;
      middle_q <= '0;
    end else begin
      state   <= state_d;
      ready_q <= (state_d == IDLE);
      if (accept) begin
        x_q      <= nxt_x;
        y_q      <= nxt_y;
        line_q   <= nxt_line;
        rows_q   <= nxt_rows;
        done_q   <= nxt_done;
        pix_q    <= I_PIX_DATA;
        pix_x    <= pos_x;
        pix_y    <= pos_y;
        pix_line <= pos_line;
        pix_rows <= pos_rows;
        if (I_SOF)        err_q <= 1'b0;
        else if (err_set) err_q <= 1'b1;
      end
      // Rows not yet written this frame read as zero instead of stale RAM data.
      if (state == RD1) oldest_q <= pix_rows[1] ? I_RAM_RDATA : '0;
      if (state == CAP) middle_q <= (pix_rows != 2'd0) ? I_RAM_RDATA : '0;
    end
  end

  lb_addr_gen #(
    .H_PIXELS (H_PIXELS),
    .ADDR_W   (ADDR_W)
  ) u_addr_gen (
    .line_idx (rd_line),
    .x        (pix_x),
    .addr     (gen_addr)
  );

  assign O_PIX_READY = ready_q;
  assign O_RAM_EN    = ram_en;
  assign O_RAM_WE    = ram_we;
  assign O_RAM_ADDR  = ram_en ? gen_addr : '0;
  assign O_RAM_WDATA = (state == WR) ? pix_q : '0;
  assign O_COL_VALID = (state == OUT);
  assign O_COL_DATA  = {oldest_q, middle_q, pix_q};
  assign O_COL_X     = pix_x;
  assign O_COL_Y     = pix_y;
  assign O_ERR_SYNC  = err_q;

endmodule

// File: tb/tb_line_buffer_scheduler.sv
// Scoreboard bench for line_buffer_scheduler: reference model built from frame
// coordinates and a 3-line store, with a 1-cycle-latency SRAM model.
module tb_line_buffer_scheduler;

  localparam int H  = 8;
  localparam int V  = 4;
  localparam int AW = 5;

  typedef struct packed {
    logic [23:0] data;
    logic [9:0]  x;
    logic [8:0]  y;
    logic        err;
  } exp_t;

  logic          clk       = 1'b0;
  logic          rst       = 1'b0;
  logic          pix_valid = 1'b0;
  logic [7:0]    pix_data  = '0;
  logic          sof       = 1'b0;
  logic          sol       = 1'b0;
  logic          pix_ready;
  logic          ram_en;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_wdata;
  logic [7:0]    ram_rdata = '0;
  logic          col_valid;
  logic [23:0]   col_data;
  logic [9:0]    col_x;
  logic [8:0]    col_y;
  logic          col_ready = 1'b1;
  logic          err_sync;
  logic [60:0]   all_outs;

  int   n_cmp      = 0;
  int   n_bad      = 0;
  int   n_cols     = 0;
  int   ready_mode = 0;
  bit   directed   = 1'b0;
  exp_t q[$];

  logic [7:0] mem [2**AW];
  logic [7:0] ref_lines [3][H];
  int   m_r   = 0;
  int   m_px  = 0;
  bit   m_err = 1'b0;

  always #5 clk = ~clk;

  line_buffer_scheduler #(
    .H_PIXELS (H),
    .V_LINES  (V),
    .ADDR_W   (AW)
  ) dut (
    .I_CORE_CLK  (clk),
    .I_RST       (rst),
    .I_PIX_VALID (pix_valid),
    .I_PIX_DATA  (pix_data),
    .I_SOF       (sof),
    .I_SOL       (sol),
    .O_PIX_READY (pix_ready),
    .O_RAM_EN    (ram_en),
    .O_RAM_WE    (ram_we),
    .O_RAM_ADDR  (ram_addr),
    .O_RAM_WDATA (ram_wdata),
    .I_RAM_RDATA (ram_rdata),
    .O_COL_VALID (col_valid),
    .O_COL_DATA  (col_data),
    .O_COL_X     (col_x),
    .O_COL_Y     (col_y),
    .I_COL_READY (col_ready),
    .O_ERR_SYNC  (err_sync)
  );

  assign all_outs = {pix_ready, ram_en, ram_we, ram_addr, ram_wdata,
                     col_valid, col_data, col_x, col_y, err_sync};

  initial for (int i = 0; i < 2**AW; i++) mem[i] <= 8'h00;

  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata     <= mem[ram_addr];
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: pixel lands at frame row m_r / column m_px; the column is the same
  // x from the two previous rows of this frame (zero if that row does not exist).
  task automatic model_accept(input logic [7:0] d, input bit s_sof, input bit s_sol,
                              output int r_o, output int px_o);
    exp_t e;
    if (s_sof) begin
      m_r = 0; m_px = 0; m_err = 1'b0;
    end else begin
      if (s_sol && m_px != 0) begin
        m_err = 1'b1; m_r++; m_px = 0;
      end
      if (m_r >= V) m_err = 1'b1;
    end
    ref_lines[m_r % 3][m_px] = d;
    e.data = {(m_r >= 2) ? ref_lines[(m_r - 2) % 3][m_px] : 8'h00,
              (m_r >= 1) ? ref_lines[(m_r - 1) % 3][m_px] : 8'h00, d};
    e.x   = 10'(m_px);
    e.y   = 9'((m_r >= V) ? V - 1 : m_r);
    e.err = m_err;
    q.push_back(e);
    r_o  = m_r;
    px_o = m_px;
    m_px++;
    if (m_px == H) begin
      m_px = 0; m_r++;
    end
  endtask

  task automatic send_pixel(input logic [7:0] d, input bit s_sof, input bit s_sol, input bit lat);
    int waited;
    int r, px;
    waited = 0;
    pix_valid = 1'b1; pix_data = d; sof = s_sof; sol = s_sol;
    do begin
      @(negedge clk);
      waited++;
      if (waited > 300) begin
        $display("FAIL accept_timeout: got O_PIX_READY=0 expected 1 within 300 cycles");
        $fatal(1, "accept timeout");
      end
    end while (!pix_ready);
    @(posedge clk); #1;
    pix_valid = 1'b0; sof = 1'b0; sol = 1'b0; pix_data = 8'($urandom);
    model_accept(d, s_sof, s_sol, r, px);
    if (lat) begin
      @(negedge clk);
      check("lat_wr_strobe", 64'({ram_en, ram_we}), 64'(2'b11));
      check("lat_wr_addr", 64'(ram_addr), 64'((r % 3) * H + px));
      check("lat_wr_data", 64'(ram_wdata), 64'(d));
      @(negedge clk);
      check("lat_rd0", 64'({ram_en, ram_we, ram_addr}),
            64'({1'b1, 1'b0, AW'(((r + 1) % 3) * H + px)}));
      @(negedge clk);
      check("lat_rd1", 64'({ram_en, ram_we, ram_addr}),
            64'({1'b1, 1'b0, AW'(((r + 2) % 3) * H + px)}));
      @(negedge clk);
      check("lat_cap_quiet", 64'({ram_en, col_valid}), 64'(0));
      @(negedge clk);
      check("lat_col_valid", 64'(col_valid), 64'(1));
      @(posedge clk); #1;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_empty", 64'(q.size()), 64'(0));
  endtask

  task automatic gap();
    repeat ($urandom_range(0, 3)) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    col_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       col_ready = 1'b1;
        1:       col_ready = 1'b0;
        default: col_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: pops the scoreboard on every column handshake, checks hold behaviour.
  initial begin : monitor
    exp_t        e;
    logic [42:0] prev_col;
    bit          prev_hold;
    prev_hold = 1'b0;
    prev_col  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_hold = 1'b0;
        continue;
      end
      if (prev_hold) begin
        check("hold_valid", 64'(col_valid), 64'(1));
        check("hold_col", 64'({col_data, col_x, col_y}), 64'(prev_col));
      end
      if (col_valid) begin
        check("out_no_ready", 64'(pix_ready), 64'(0));
        check("out_no_ram", 64'(ram_en), 64'(0));
      end
      if (col_valid && col_ready) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_col: got column x=%0d y=%0d expected none", col_x, col_y);
        end else begin
          e = q.pop_front();
          n_cols++;
          check("col_data", 64'(col_data), 64'(e.data));
          check("col_x", 64'(col_x), 64'(e.x));
          check("col_y", 64'(col_y), 64'(e.y));
          check("col_err", 64'(err_sync), 64'(e.err));
          if (directed && col_x == 10'd3 && col_y == 9'd2)
            check("frame_col_3_2", 64'(col_data), 64'(24'h030B13));
          if (directed && col_x == 10'd0 && col_y == 9'd0)
            check("frame_col_0_0", 64'(col_data), 64'(24'h000000));
        end
      end
      prev_hold = col_valid && !col_ready;
      prev_col  = {col_data, col_x, col_y};
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    int n;
    for (int l = 0; l < 3; l++)
      for (int c = 0; c < H; c++) ref_lines[l][c] = 8'h00;

    #1 rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("reset_outputs", 64'(all_outs), 64'(0));
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Ramp frame: value = y*8 + x, latency probe at (x=0, y=3)
    directed = 1'b1;
    for (int y = 0; y < V; y++)
      for (int x = 0; x < H; x++)
        send_pixel(8'(y * H + x), (x == 0 && y == 0), 1'b0, (x == 0 && y == 3));
    drain();
    directed = 1'b0;

    // Backpressure
    ready_mode = 1;
    send_pixel(8'h5A, 1'b1, 1'b0, 1'b0);
    n = 0;
    while (!col_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("bp_col_valid", 64'(col_valid), 64'(1));
    repeat (20) @(negedge clk);
    check("bp_still_valid", 64'(col_valid), 64'(1));
    @(posedge clk); #1;
    ready_mode = 0;
    drain();

    // Sync error: SOL arriving at x=5 of row 1
    send_pixel(8'h10, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i < H + 5; i++) send_pixel(8'(8'h20 + i), 1'b0, 1'b0, 1'b0);
    send_pixel(8'hEE, 1'b0, 1'b1, 1'b0);
    drain();
    check("sync_err_set", 64'(err_sync), 64'(1));
    send_pixel(8'h44, 1'b1, 1'b0, 1'b0);
    drain();
    check("sync_err_cleared", 64'(err_sync), 64'(0));

    // Reset while the scheduler is reading
    send_pixel(8'hA5, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #2;
    rst = 1'b1;
    q.delete();
    m_r = 0; m_px = 0; m_err = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("reset_mid_outputs", 64'(all_outs), 64'(0));
    end
    @(posedge clk); #1;
    rst = 1'b0;
    send_pixel(8'h3C, 1'b0, 1'b0, 1'b0);
    drain();

    // Randomised frames with stray SOL, backpressure and one overlong frame
    ready_mode = 2;
    for (int f = 0; f < 4; f++) begin
      int npix;
      npix = H * V + ((f == 2) ? 6 : 0);
      for (int i = 0; i < npix; i++) begin
        send_pixel(8'($urandom), (i == 0), ($urandom_range(0, 11) == 0), 1'b0);
        gap();
      end
    end
    ready_mode = 0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
